// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the writeback, long-latency and regfile write signals shared by the arbiter.
// The master modport belongs to the surrounding pipeline and the slave modport to the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int REG_ADDR_W = 5,
    parameter int REG_DATA_W = 32,
    parameter int FIFO_DEPTH = 2
);
    logic                          wb_wr_enable;
    logic [REG_ADDR_W-1:0]         wb_wr_addr;
    logic [REG_DATA_W-1:0]         wb_wr_data;
    logic                          wb_stall;
    logic                          lu_valid;
    logic                          lu_ready;
    logic [REG_ADDR_W-1:0]         lu_addr;
    logic [REG_DATA_W-1:0]         lu_data;
    logic                          wr_enable;
    logic [REG_ADDR_W-1:0]         wr_addr;
    logic [REG_DATA_W-1:0]         wr_data;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output wb_wr_enable, wb_wr_addr, wb_wr_data,
        output lu_valid, lu_addr, lu_data,
        input  wb_stall, lu_ready, wr_enable, wr_addr, wr_data, fifo_count
    );

    modport slave (
        input  wb_wr_enable, wb_wr_addr, wb_wr_data,
        input  lu_valid, lu_addr, lu_data,
        output wb_stall, lu_ready, wr_enable, wr_addr, wr_data, fifo_count
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between writeback (priority) and a queued long-latency unit,
// with a starvation counter that forces a queued write through and stalls writeback.
module regfile_wr_arbiter #(
    parameter int REG_ADDR_W   = 5,
    parameter int REG_DATA_W   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             reset,
    regfile_wr_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [REG_ADDR_W-1:0] addrMem_q [FIFO_DEPTH];
    logic [REG_DATA_W-1:0] dataMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [SC_W-1:0]       starveCnt_q, starveCnt_d;

    logic queueEmpty;
    logic queueFull;
    logic aReq;
    logic forceB;
    logic grantA;
    logic grantB;
    logic push;
    logic pop;

    // Grant decision and regfile drive; everything is suppressed while reset is high.
    always_comb begin
        queueEmpty    = (count_q == '0);
        queueFull     = (count_q == FULL_CNT);
        aReq          = bus.wb_wr_enable && (bus.wb_wr_addr != '0);
        forceB        = !queueEmpty && (starveCnt_q >= STARVE_MAX);
        grantB        = !reset && (forceB || (!aReq && !queueEmpty));
        grantA        = !reset && !forceB && aReq;
        push          = !reset && bus.lu_valid && !queueFull && (bus.lu_addr != '0);
        pop           = grantB;

        bus.lu_ready   = !queueFull;
        bus.wb_stall   = !reset && forceB && aReq;
        bus.fifo_count = count_q;
        bus.wr_enable  = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        if (grantB) begin
            bus.wr_enable = 1'b1;
            bus.wr_addr   = addrMem_q[rdPtr_q];
            bus.wr_data   = dataMem_q[rdPtr_q];
        end else if (grantA) begin
            bus.wr_enable = 1'b1;
            bus.wr_addr   = bus.wb_wr_addr;
            bus.wr_data   = bus.wb_wr_data;
        end
    end

    // Queue bookkeeping and the saturating starvation counter.
    always_comb begin
        rdPtr_d     = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        wrPtr_d     = push ? wrPtr_q + 1'b1 : wrPtr_q;
        count_d     = count_q;
        starveCnt_d = starveCnt_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (queueEmpty || grantB) begin
            starveCnt_d = '0;
        end else if (starveCnt_q < STARVE_MAX) begin
            starveCnt_d = starveCnt_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            starveCnt_q <= '0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    // Entry storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wrPtr_q] <= bus.lu_addr;
            dataMem_q[wrPtr_q] <= bus.lu_data;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected regfile writes are queued as stimulus is
// driven and popped by a monitor whenever the arbiter writes.
module tb_regfile_wr_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wrEntry_t;

    logic clk;
    logic reset;
    int   compareCount;
    int   errorCount;
    wrEntry_t expQ[$];

    regfile_wr_arbiter_if #(.REG_ADDR_W(AW), .REG_DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    regfile_wr_arbiter #(
        .REG_ADDR_W(AW), .REG_DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wbEn, input logic [AW-1:0] wbAddr, input logic [DW-1:0] wbData,
                                 input logic luV, input logic [AW-1:0] luAddr, input logic [DW-1:0] luData);
        bus.wb_wr_enable = wbEn;
        bus.wb_wr_addr   = wbAddr;
        bus.wb_wr_data   = wbData;
        bus.lu_valid     = luV;
        bus.lu_addr      = luAddr;
        bus.lu_data      = luData;
    endtask

    task automatic expectWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wrEntry_t e;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every regfile write must match the oldest expected write; invariants checked each cycle.
    always @(negedge clk) begin
        wrEntry_t e;
        if (reset) begin
            checkOutput("rstNoWr", 64'(bus.wr_enable), 64'd0);
        end else if (bus.wr_enable) begin
            checkOutput("wrNotX0", 64'(bus.wr_addr == '0), 64'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWr", 64'(bus.wr_addr), 64'hFFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("wrAddr", 64'(bus.wr_addr), 64'(e.addr));
                checkOutput("wrData", 64'(bus.wr_data), 64'(e.data));
            end
        end
        if (bus.wb_stall) begin
            checkOutput("stallImpliesB", 64'(bus.wr_enable && (bus.wr_addr != bus.wb_wr_addr)), 64'd1);
        end
        if (bus.fifo_count > DEPTH) begin
            checkOutput("countBound", 64'(bus.fifo_count), 64'(DEPTH));
        end
    end

    initial begin
        compareCount = 0;
        errorCount   = 0;
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset then idle");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idleWrEn", 64'(bus.wr_enable), 64'd0);
            checkOutput("idleReady", 64'(bus.lu_ready), 64'd1);
            checkOutput("idleCount", 64'(bus.fifo_count), 64'd0);
            nextCycle();
        end

        $display("[TB] port A only");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        expectWrite(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("aOnlyWrEn", 64'(bus.wr_enable), 64'd1);
        checkOutput("aOnlyStall", 64'(bus.wb_stall), 64'd0);
        nextCycle();

        $display("[TB] port B only");
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h12);
        expectWrite(5'd7, 32'h12);
        @(negedge clk);
        checkOutput("bOnlyReady", 64'(bus.lu_ready), 64'd1);
        checkOutput("bOnlyNoBypass", 64'(bus.wr_enable), 64'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("bOnlyCount1", 64'(bus.fifo_count), 64'd1);
        checkOutput("bOnlyWrEn", 64'(bus.wr_enable), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("bOnlyCount0", 64'(bus.fifo_count), 64'd0);
        checkOutput("bOnlyIdle", 64'(bus.wr_enable), 64'd0);
        nextCycle();

        $display("[TB] starvation");
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
        nextCycle();
        for (int k = 1; k <= LIMIT; k++) begin
            applyStimulus(1'b1, 5'd3, 32'h30 + 32'(k), 1'b0, '0, '0);
            expectWrite(5'd3, 32'h30 + 32'(k));
            @(negedge clk);
            checkOutput("starveAStall", 64'(bus.wb_stall), 64'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 5'd3, 32'h35, 1'b0, '0, '0);
        expectWrite(5'd9, 32'h99);
        expectWrite(5'd3, 32'h35);
        @(negedge clk);
        checkOutput("forceStall", 64'(bus.wb_stall), 64'd1);
        checkOutput("forceCount", 64'(bus.fifo_count), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("heldAStall", 64'(bus.wb_stall), 64'd0);
        checkOutput("heldACount", 64'(bus.fifo_count), 64'd0);
        nextCycle();

        $display("[TB] full queue");
        applyStimulus(1'b1, 5'd3, 32'h40, 1'b1, 5'd1, 32'h101);
        expectWrite(5'd3, 32'h40);
        @(negedge clk);
        checkOutput("fullReady0", 64'(bus.lu_ready), 64'd1);
        nextCycle();
        applyStimulus(1'b1, 5'd3, 32'h41, 1'b1, 5'd2, 32'h102);
        expectWrite(5'd3, 32'h41);
        @(negedge clk);
        checkOutput("fullReady1", 64'(bus.lu_ready), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 32'h104);
        expectWrite(5'd1, 32'h101);
        @(negedge clk);
        checkOutput("fullReadyLow", 64'(bus.lu_ready), 64'd0);
        checkOutput("fullCount2", 64'(bus.fifo_count), 64'd2);
        nextCycle();
        expectWrite(5'd2, 32'h102);
        @(negedge clk);
        checkOutput("fullReadyBack", 64'(bus.lu_ready), 64'd1);
        checkOutput("fullCount1", 64'(bus.fifo_count), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        expectWrite(5'd4, 32'h104);
        @(negedge clk);
        checkOutput("fullPushPop", 64'(bus.fifo_count), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("fullDrained", 64'(bus.fifo_count), 64'd0);
        nextCycle();

        $display("[TB] x0 handling");
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
        @(negedge clk);
        checkOutput("x0LuReady", 64'(bus.lu_ready), 64'd1);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 32'h77, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("x0LuCount", 64'(bus.fifo_count), 64'd0);
        checkOutput("x0WbWrEn", 64'(bus.wr_enable), 64'd0);
        checkOutput("x0WbStall", 64'(bus.wb_stall), 64'd0);
        nextCycle();

        $display("[TB] reset with queued entries");
        applyStimulus(1'b1, 5'd3, 32'h50, 1'b1, 5'd10, 32'hA0);
        expectWrite(5'd3, 32'h50);
        nextCycle();
        applyStimulus(1'b1, 5'd3, 32'h51, 1'b1, 5'd11, 32'hB0);
        expectWrite(5'd3, 32'h51);
        @(negedge clk);
        checkOutput("rstPreCount1", 64'(bus.fifo_count), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstPreCount2", 64'(bus.fifo_count), 64'd2);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstCount", 64'(bus.fifo_count), 64'd0);
        checkOutput("rstWrEn", 64'(bus.wr_enable), 64'd0);
        checkOutput("rstReady", 64'(bus.lu_ready), 64'd1);
        repeat (3) nextCycle();

        checkOutput("scbEmpty", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port between the in-order writeback stage (port A) and a long-latency result unit such as a multiply/divide or miss-return unit (port B). Port B results are queued in a small FIFO. Port A has priority, but a starvation counter forces a port B grant and stalls writeback for one cycle. The block sits between writeback, the long-latency unit and the regfile write interface.

Parameters:
REG_ADDR_W, 5, register address width
REG_DATA_W, 32, register data width
FIFO_DEPTH, 2, port B queue entries; power of two, 2 or greater
STARVE_LIMIT, 4, cycles a non-empty queue head may be denied before a forced grant; 1 or greater

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_wr_enable  in  1  writeback requests a write this cycle
wb_wr_addr  in  REG_ADDR_W  writeback destination
wb_wr_data  in  REG_DATA_W  writeback data
wb_stall  out  1  writeback write not performed this cycle; writeback must hold its inputs
lu_valid  in  1  long-latency result offered
lu_ready  out  1  arbiter accepts the result this cycle
lu_addr  in  REG_ADDR_W  long-latency destination
lu_data  in  REG_DATA_W  long-latency data
wr_enable  out  1  regfile write enable
wr_addr  out  REG_ADDR_W  regfile write address
wr_data  out  REG_DATA_W  regfile write data
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied queue entries

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high: on a reset edge the queue empties, fifo_count=0 and starve_cnt=0.
- After reset: wr_enable=0, wb_stall=0, lu_ready=1.
- Reset asserted mid-operation discards all queued entries. No write occurs in a cycle where reset is high; wr_enable=0 is forced.
- lu_ready = (fifo_count != FIFO_DEPTH). It is combinational and does not take a same-cycle pop into account.
- Push: lu_valid && lu_ready at a clock edge enqueues {lu_addr, lu_data}. lu_addr==0 is accepted but not enqueued (x0 writes are discarded).
- Minimum latency from B acceptance to regfile write is 1 cycle. There is no same-cycle bypass.
- Grant logic is combinational, evaluated each cycle with head = oldest queue entry:
  - force = queue non-empty && starve_cnt >= STARVE_LIMIT.
  - A_req = wb_wr_enable && wb_wr_addr != 0. A write to x0 is silently dropped and wb_stall=0.
  - If force: grant B; wb_stall = A_req.
  - Else if A_req: grant A; wb_stall=0.
  - Else if queue non-empty: grant B.
  - Else: no grant; wr_enable=0.
- Grant A drives wr_enable=1, wr_addr=wb_wr_addr, wr_data=wb_wr_data.
- Grant B drives wr_enable=1 with the head address and data, and pops the head at the clock edge.
- starve_cnt, sequential:
  - Cleared on any B grant or when the queue is empty.
  - Incremented when the queue is non-empty and B is not granted.
  - Saturates at STARVE_LIMIT.
- Simultaneous push and pop: both take effect and fifo_count is unchanged. When full, no push occurs even if a pop happens in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Outputs wr_* are combinational from the current inputs and the queue head. When wr_enable=0 they are don't-care; drive 0.
- The block does not reorder or check hazards. WAW/RAW ordering between A and B targets is the responsibility of issue logic.
- Assertions for the bench:
  - wr_enable never drives address 0.
  - wb_stall implies a B grant.
  - fifo_count never exceeds FIFO_DEPTH.

Test Plan:
- Reset then idle: wr_enable=0, lu_ready=1 and fifo_count=0 for 5 cycles.
- A only: wb_wr_enable=1, addr=5, data=0xDEADBEEF -> same cycle wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF, wb_stall=0.
- B only: push addr=7, data=0x12 at edge N -> fifo_count=1 after N; cycle N+1 writes r7=0x12; fifo_count=0 after N+1.
- Starvation, STARVE_LIMIT=4: queue holds r9, A writes continuously to r3 -> A is granted for 4 cycles, then on the 5th cycle B writes r9 with wb_stall=1; the next cycle A's held r3 write completes.
- Full queue, FIFO_DEPTH=2:
  - Push r1 and r2 while A busy -> lu_ready=0.
  - A drops, B pops r1 while lu_valid offers r4 -> not accepted that cycle, accepted the next.
  - Order of writes is r1, r2, r4.
- x0 and reset:
  - lu_addr=0 accepted with fifo_count unchanged.
  - wb_wr_addr=0 gives no write.
  - Reset asserted with 2 entries queued -> fifo_count=0 next cycle and no B writes follow.
